// File: rtl/rv32_mmio_uart_tx.sv
// Memory-mapped UART transmitter: a 16-byte register window on the core data bus
// feeding a small TX FIFO that is serialised as 8N1 frames on the tx pin.
module rv32_mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
  parameter int unsigned CLK_DIV_RESET = 434,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] data_request_addr,
  input  logic [1:0]  data_request_op,
  input  logic [31:0] data_request_data,
  output logic        request_done,
  output logic [31:0] data,
  output logic        tx,
  output logic        tx_idle
);

  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [15:0]       timer, timer_n;
  logic [2:0]        bit_idx, bit_n;
  logic [7:0]        shift, shift_n;
  logic              pop;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  count;
  logic              fifo_full, fifo_empty;

  logic [15:0]       divisor;
  logic              overflow;
  logic              hit, rd, wr, push;
  logic [1:0]        reg_idx;
  logic [31:0]       status, rdata;
  logic              unused_bits;

  assign unused_bits = ^{data_request_addr[1:0], data_request_data[31:16]};

  assign hit     = resetn && (data_request_op != MEM_NOP) &&
                   (data_request_addr[31:4] == BASE_ADDR[31:4]);
  assign rd      = hit && (data_request_op == MEM_READ);
  assign wr      = hit && (data_request_op == MEM_WRITE);
  assign reg_idx = data_request_addr[3:2];

  assign request_done = hit;

  assign fifo_full  = (count == DEPTH_CNT);
  assign fifo_empty = (count == '0);
  // A push against a full FIFO is dropped even when a pop happens on the same edge.
  assign push       = wr && (reg_idx == 2'd0) && !fifo_full;

  assign tx_idle = (state == IDLE) && fifo_empty;

  always_comb begin
    status       = '0;
    status[0]    = fifo_full;
    status[1]    = fifo_empty;
    status[2]    = (state != IDLE);
    status[3]    = overflow;
    status[11:8] = 4'(count);
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      2'd1:    rdata = status;
      2'd2:    rdata = {16'd0, divisor};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data     <= '0;
      overflow <= 1'b0;
      divisor  <= 16'(CLK_DIV_RESET);
    end else begin
      if (rd) data <= rdata;
      if (rd && reg_idx == 2'd1) overflow <= 1'b0;
      else if (wr && reg_idx == 2'd0 && fifo_full) overflow <= 1'b1;
      if (wr && reg_idx == 2'd2)
        divisor <= (data_request_data[15:0] == 16'd0) ? 16'd1 : data_request_data[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data_request_data[7:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
    end
  end

  // The bit timer is only reloaded at bit boundaries, so a divisor change lands on the next bit.
  always_comb begin
    state_n = state;
    timer_n = timer;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    tx      = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = mem[rptr];
          timer_n = divisor;
          state_n = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (timer < 16'd2) begin
          timer_n = divisor;
          bit_n   = 3'd0;
          state_n = DATA;
        end else begin
          timer_n = timer - 16'd1;
        end
      end
      DATA: begin
        tx = shift[bit_idx];
        if (timer < 16'd2) begin
          timer_n = divisor;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          timer_n = timer - 16'd1;
        end
      end
      STOP: begin
        if (timer < 16'd2) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = mem[rptr];
            timer_n = divisor;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          timer_n = timer - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rv32_mmio_uart_tx.sv
// Scoreboard bench for rv32_mmio_uart_tx: a queue-level model predicts read data,
// FIFO occupancy and transmitted bytes; monitors decode the DUT outputs and compare.
module tb_rv32_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 8;
  localparam logic [1:0]  OP_NOP   = 2'd0;
  localparam logic [1:0]  OP_READ  = 2'd1;
  localparam logic [1:0]  OP_WRITE = 2'd2;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_op = OP_NOP;
  logic [31:0] req_wdata = '0;
  logic        request_done;
  logic [31:0] data;
  logic        tx;
  logic        tx_idle;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue, remaining cycles of the current frame.
  logic [7:0]  m_fifo[$];
  int          m_left = 0;
  int          m_div = 434;
  bit          m_ovf = 1'b0;
  logic [31:0] m_data = '0;
  bit          prev_read = 1'b0;

  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];
  bit          rx_active = 1'b0;

  rv32_mmio_uart_tx #(
    .BASE_ADDR(BASE), .CLK_DIV_RESET(434), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn),
    .data_request_addr(req_addr), .data_request_op(req_op), .data_request_data(req_wdata),
    .request_done(request_done), .data(data), .tx(tx), .tx_idle(tx_idle)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk);
    #1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(OP_NOP, 32'h0, 32'h0);
  endtask

  task automatic expectData(input string name, input logic [31:0] value);
    @(negedge clk);
    #1;
    checkOutput(name, data, value);
  endtask

  task automatic waitIdle(input int budget);
    bit done;
    done = 1'b0;
    applyStimulus(OP_NOP, 32'h0, 32'h0);
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      done = (m_fifo.size() == 0) && (m_left == 0) && !rx_active && (tx_q.size() == 0) && tx_idle;
    end
    checkOutput("drain_within_budget", 32'(done), 32'h1);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    resetn    = 1'b0;
    req_op    = OP_READ;
    req_addr  = BASE + 32'd4;
    req_wdata = '0;
    #1;
    checkOutput("reset_tx_immediate", 32'(tx), 32'h1);
    checkOutput("reset_done_gated", 32'(request_done), 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    req_op = OP_NOP;
  endtask

  // Model: evaluates each cycle's request at the negedge, i.e. before the edge that commits it.
  initial begin : model_p
    bit          h;
    bit          busy;
    bit          pop;
    int          idx;
    int          cnt;
    logic [31:0] st;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_fifo.delete();
        rd_q.delete();
        tx_q.delete();
        m_left    = 0;
        m_div     = 434;
        m_ovf     = 1'b0;
        m_data    = '0;
        prev_read = 1'b0;
        checkOutput("reset_tx", 32'(tx), 32'h1);
        checkOutput("reset_tx_idle", 32'(tx_idle), 32'h1);
        checkOutput("reset_data", data, 32'h0);
      end else begin
        h    = (req_op != OP_NOP) && (req_addr[31:4] == BASE[31:4]);
        idx  = int'(req_addr[3:2]);
        cnt  = m_fifo.size();
        busy = (m_left > 0);
        checkOutput("request_done", 32'(request_done), 32'(h));
        checkOutput("tx_idle", 32'(tx_idle), 32'((cnt == 0) && !busy));
        if (!prev_read) checkOutput("data_hold", data, m_data);
        prev_read = h && (req_op == OP_READ);
        if (prev_read) begin
          case (idx)
            1:       st = {20'd0, 4'(cnt), 4'd0, m_ovf, busy, (cnt == 0), (cnt == DEPTH)};
            2:       st = 32'(m_div);
            default: st = 32'h0;
          endcase
          rd_q.push_back(st);
          m_data = st;
          if (idx == 1) m_ovf = 1'b0;
        end
        pop = (cnt > 0) && (!busy || m_left == 1);
        if (busy) m_left--;
        if (pop) begin
          tx_q.push_back(m_fifo.pop_front());
          m_left = 10 * m_div;
        end
        if (h && req_op == OP_WRITE) begin
          if (idx == 0) begin
            if (cnt == DEPTH) m_ovf = 1'b1;
            else              m_fifo.push_back(req_wdata[7:0]);
          end else if (idx == 2) begin
            m_div = (req_wdata[15:0] == 16'd0) ? 1 : int'(req_wdata[15:0]);
          end
        end
      end
    end
  end

  // Read monitor: data is compared one cycle after the DUT acknowledges a read.
  initial begin : read_mon
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (seen && resetn) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL read_unexpected actual=%h expected=none", data);
        end else begin
          checkOutput("read_data", data, rd_q.pop_front());
        end
      end
      seen = resetn && request_done && (req_op == OP_READ);
    end
  end

  // UART receiver: samples mid-bit and checks each decoded byte against the expected queue.
  initial begin : rx_mon
    int         rx_cnt;
    int         rx_div;
    int         k;
    logic [7:0] rx_byte;
    rx_cnt  = 0;
    rx_div  = 1;
    rx_byte = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        rx_active = 1'b0;
      end else begin
        if (!rx_active) begin
          if (tx == 1'b0) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
            rx_div    = m_div;
          end
        end else begin
          rx_cnt++;
        end
        if (rx_active && (rx_cnt % rx_div) == rx_div / 2) begin
          k = rx_cnt / rx_div;
          if (k == 0) begin
            checkOutput("start_bit", 32'(tx), 32'h0);
          end else if (k <= 8) begin
            rx_byte[k-1] = tx;
          end else begin
            checkOutput("stop_bit", 32'(tx), 32'h1);
            if (tx_q.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_frame actual=%h expected=none", rx_byte);
            end else begin
              checkOutput("tx_byte", 32'(rx_byte), 32'(tx_q.pop_front()));
            end
            rx_active = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int r;
    #2;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    applyStimulus(OP_READ, BASE + 32'd4, 32'h0);
    applyStimulus(OP_READ, BASE + 32'd8, 32'h0);
    expectData("reset_status_word", 32'h0000_0002);
    applyStimulus(OP_NOP, 32'h0, 32'h0);
    expectData("reset_divisor", 32'd434);

    applyStimulus(OP_WRITE, BASE + 32'd8, 32'd4);
    applyStimulus(OP_WRITE, BASE, 32'hA5);
    waitIdle(200);

    applyStimulus(OP_WRITE, BASE + 32'd8, 32'd16);
    for (int i = 0; i < 9; i++) applyStimulus(OP_WRITE, BASE, 32'h10 + 32'(i));
    applyStimulus(OP_READ, BASE + 32'd4, 32'h0);
    applyStimulus(OP_WRITE, BASE, 32'hEE);
    expectData("status_full_no_overflow", 32'h0000_0805);
    applyStimulus(OP_READ, BASE + 32'd4, 32'h0);
    applyStimulus(OP_READ, BASE + 32'd4, 32'h0);
    expectData("status_overflow_sticky", 32'h0000_080D);
    applyStimulus(OP_NOP, 32'h0, 32'h0);
    expectData("status_overflow_cleared", 32'h0000_0805);
    waitIdle(2500);

    applyStimulus(OP_READ, BASE + 32'd8, 32'h0);
    applyStimulus(OP_WRITE, BASE + 32'd16, 32'h55);
    applyStimulus(OP_READ, BASE + 32'd16, 32'h0);
    applyStimulus(OP_NOP, BASE, 32'h66);
    applyStimulus(OP_WRITE, BASE ^ 32'h1000_0000, 32'h77);
    applyStimulus(OP_READ, BASE + 32'd12, 32'h0);
    applyStimulus(OP_WRITE, BASE + 32'd12, 32'hFFFF_FFFF);
    applyStimulus(OP_READ, BASE, 32'h0);
    applyStimulus(OP_READ, BASE + 32'd8, 32'h0);
    expectData("reserved_write_ignored", 32'h0);
    idleCycles(3);

    applyStimulus(OP_WRITE, BASE + 32'd8, 32'd4);
    applyStimulus(OP_WRITE, BASE, 32'h3C);
    idleCycles(16);
    pulseReset();
    applyStimulus(OP_READ, BASE + 32'd8, 32'h0);
    applyStimulus(OP_READ, BASE + 32'd4, 32'h0);
    expectData("post_reset_divisor", 32'd434);
    applyStimulus(OP_NOP, 32'h0, 32'h0);
    expectData("post_reset_status", 32'h0000_0002);
    idleCycles(60);

    applyStimulus(OP_WRITE, BASE + 32'd8, 32'h0);
    applyStimulus(OP_READ, BASE + 32'd8, 32'h0);
    applyStimulus(OP_WRITE, BASE, 32'h00);
    expectData("divisor_zero_stores_one", 32'd1);
    waitIdle(100);

    applyStimulus(OP_WRITE, BASE + 32'd8, 32'd2);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: applyStimulus(OP_WRITE, BASE, 32'($urandom_range(0, 255)));
        4:          applyStimulus(OP_READ, BASE + 32'd4, 32'h0);
        5:          applyStimulus(OP_READ, BASE + 32'(4 * $urandom_range(0, 3)), 32'h0);
        6:          applyStimulus($urandom_range(0, 1) ? OP_WRITE : OP_READ,
                                  BASE + 32'd16 + 32'(4 * $urandom_range(0, 255)), $urandom);
        7:          applyStimulus(OP_NOP, BASE + 32'(4 * $urandom_range(0, 3)), $urandom);
        8: begin
          if (m_fifo.size() == 0 && m_left == 0)
            applyStimulus(OP_WRITE, BASE + 32'd8, 32'($urandom_range(0, 3)));
          else
            applyStimulus(OP_NOP, 32'h0, 32'h0);
        end
        default:    applyStimulus(OP_WRITE, BASE + ($urandom_range(0, 1) ? 32'd4 : 32'd12), $urandom);
      endcase
    end
    waitIdle(5000);
    idleCycles(2);

    checkOutput("read_queue_empty", 32'(rd_q.size()), 32'h0);
    checkOutput("tx_queue_empty", 32'(tx_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
